// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 16-bit ALU between two valid/ready requesters.
// An accepted operation is registered onto the ALU inputs and held for LAT cycles
// (MULDIV_LAT for mul/div). The ALU outputs are then captured into a response
// register, which is held until the consumer accepts it.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: port 0 always wins a simultaneous
// request. Without it, simultaneous requests are granted round-robin.
module alu_arbiter #(
    parameter int LAT        = 1,
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [3:0]  req0_op,
    input  logic [15:0] req0_x,
    input  logic [15:0] req0_y,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [3:0]  req1_op,
    input  logic [15:0] req1_x,
    input  logic [15:0] req1_y,
    output logic        req1_ready,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_carry,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_carry,
    output logic        rsp_err
);

    localparam int MAXL = (LAT > MULDIV_LAT) ? LAT : MULDIV_LAT;
    localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    aluOp_q, aluOp_d;
    logic [15:0]   aluX_q, aluX_d;
    logic [15:0]   aluY_q, aluY_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lastGrant_q, lastGrant_d;
    logic          rspValid_q, rspValid_d;
    logic          rspId_q, rspId_d;
    logic [15:0]   rspResult_q, rspResult_d;
    logic          rspZero_q, rspZero_d;
    logic          rspCarry_q, rspCarry_d;
    logic          rspErr_q, rspErr_d;

    logic          grant;
    logic          anyValid;
    logic [3:0]    selOp;
    logic [15:0]   selX;
    logic [15:0]   selY;

    // Pick the winning port and its payload; ready is offered only while idle and out of reset
    always_comb begin
        anyValid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~lastGrant_q;
`endif
        end else begin
            grant = ~req0_valid;
        end
        selOp      = grant ? req1_op : req0_op;
        selX       = grant ? req1_x  : req0_x;
        selY       = grant ? req1_y  : req0_y;
        req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
        req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
    end

    // Next-state logic: accept in IDLE, count down the settle time in EXEC, hold the response in RESP
    always_comb begin
        state_d     = state_q;
        aluOp_d     = aluOp_q;
        aluX_d      = aluX_q;
        aluY_d      = aluY_q;
        cnt_d       = cnt_q;
        lastGrant_d = lastGrant_q;
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspZero_d   = rspZero_q;
        rspCarry_d  = rspCarry_q;
        rspErr_d    = rspErr_q;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    aluOp_d     = selOp;
                    aluX_d      = selX;
                    aluY_d      = selY;
                    rspId_d     = grant;
                    lastGrant_d = grant;
                    if (selOp == 4'b0010 || selOp == 4'b0011) begin
                        cnt_d = CW'(MULDIV_LAT - 1);
                    end else begin
                        cnt_d = CW'(LAT - 1);
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (aluOp_q == 4'b0011 && aluY_q == 16'd0) begin
                        rspResult_d = 16'hFFFF;
                        rspZero_d   = 1'b0;
                        rspCarry_d  = 1'b0;
                        rspErr_d    = 1'b1;
                    end else begin
                        rspResult_d = alu_result;
                        rspZero_d   = alu_zero;
                        rspCarry_d  = alu_carry;
                        rspErr_d    = 1'b0;
                    end
                    rspValid_d = 1'b1;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation and favours port 0 next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aluOp_q     <= '0;
            aluX_q      <= '0;
            aluY_q      <= '0;
            cnt_q       <= '0;
            lastGrant_q <= 1'b1;
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspResult_q <= '0;
            rspZero_q   <= 1'b0;
            rspCarry_q  <= 1'b0;
            rspErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            aluOp_q     <= aluOp_d;
            aluX_q      <= aluX_d;
            aluY_q      <= aluY_d;
            cnt_q       <= cnt_d;
            lastGrant_q <= lastGrant_d;
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspZero_q   <= rspZero_d;
            rspCarry_q  <= rspCarry_d;
            rspErr_q    <= rspErr_d;
        end
    end

    assign alu_op     = aluOp_q;
    assign alu_x      = aluX_q;
    assign alu_y      = aluY_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_zero   = rspZero_q;
    assign rsp_carry  = rspCarry_q;
    assign rsp_err    = rspErr_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU attached.
// Accepted requests are queued with their accept cycle. A negedge monitor
// predicts ready, the ALU input hold, response timing and response contents.
// The prediction comes from plain arbitration and arithmetic rules.
module tb_alu_arbiter;

    localparam int LAT        = 1;
    localparam int MULDIV_LAT = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [15:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic        req0_ready, req1_ready;
    logic [3:0]  alu_op;
    logic [15:0] alu_x, alu_y, alu_result;
    logic        alu_zero, alu_carry;
    logic        rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [15:0] x;
        logic [15:0] y;
        int          acceptCyc;
    } entry_t;

    entry_t sbQ[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    logic   lastG = 1'b1;
    int     stallCycles = 0;
    bit     randReady = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.LAT(LAT), .MULDIV_LAT(MULDIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_x(req0_x), .req0_y(req0_y), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_x(req1_x), .req1_y(req1_y), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    // Behavioural ALU: returns {carry, zero, result}; divide by zero gives deliberate junk
    function automatic logic [17:0] aluFn(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [31:0] p;
        logic [15:0] r;
        logic        c;
        c = 1'b0;
        r = x;
        case (op)
            4'd0: begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16]; end
            4'd1: begin s = {1'b0, x} - {1'b0, y}; r = s[15:0]; c = s[16]; end
            4'd2: begin p = {16'd0, x} * {16'd0, y}; r = p[15:0]; c = |p[31:16]; end
            4'd3: begin
                if (y == 16'd0) return {1'b1, 1'b1, 16'h1234};
                r = x / y;
            end
            4'd4: r = x & y;
            4'd5: r = x | y;
            4'd6: r = x ^ y;
            4'd7: r = ~x;
            default: r = x;
        endcase
        return {c, (r == 16'd0), r};
    endfunction

    assign {alu_carry, alu_zero, alu_result} = aluFn(alu_op, alu_x, alu_y);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        int  n;
        bit  got;
        n = 0;
        got = 1'b0;
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y;
        end
        while (!got && n < 500) begin
            @(negedge clk);
            if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
            n++;
        end
        @(posedge clk);
        #1;
        if (port == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept_timeout port %0d: got no ready expected ready", port);
        end
    endtask

    // Consumer side: random or always-ready, with forced stall windows
    always @(posedge clk) begin
        #1;
        if (stallCycles > 0) begin
            rsp_ready = 1'b0;
            stallCycles--;
        end else begin
            rsp_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: predicts grants, ALU input hold, response timing/content; pushes and pops the scoreboard
    always @(negedge clk) begin
        logic e0, e1, free, expValid, expErr, expZero, expCarry;
        logic [17:0] a;
        logic [15:0] expRes;
        int lat;
        entry_t e, n;
        cyc++;
        if (rst_n) begin
            free = (sbQ.size() == 0);
            e0 = free && req0_valid && (!req1_valid || FIXED || lastG);
            e1 = free && req1_valid && !e0;
            checkOutput("req0_ready", 32'(req0_ready), 32'(e0));
            checkOutput("req1_ready", 32'(req1_ready), 32'(e1));
            if (!free) begin
                e = sbQ[0];
                checkOutput("alu_op", 32'(alu_op), 32'(e.op));
                checkOutput("alu_x", 32'(alu_x), 32'(e.x));
                checkOutput("alu_y", 32'(alu_y), 32'(e.y));
                lat = (e.op == 4'd2 || e.op == 4'd3) ? MULDIV_LAT : LAT;
                expValid = (cyc >= e.acceptCyc + 1 + lat);
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(expValid));
                if (expValid) begin
                    expErr = (e.op == 4'd3 && e.y == 16'd0);
                    a = aluFn(e.op, e.x, e.y);
                    expRes   = expErr ? 16'hFFFF : a[15:0];
                    expZero  = expErr ? 1'b0 : a[16];
                    expCarry = expErr ? 1'b0 : a[17];
                    checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
                    checkOutput("rsp_result", 32'(rsp_result), 32'(expRes));
                    checkOutput("rsp_zero", 32'(rsp_zero), 32'(expZero));
                    checkOutput("rsp_carry", 32'(rsp_carry), 32'(expCarry));
                    checkOutput("rsp_err", 32'(rsp_err), 32'(expErr));
                    if (rsp_ready) void'(sbQ.pop_front());
                end
            end else begin
                checkOutput("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            end
            if (e0 || e1) begin
                n.id = e1;
                n.op = e1 ? req1_op : req0_op;
                n.x  = e1 ? req1_x : req0_x;
                n.y  = e1 ? req1_y : req0_y;
                n.acceptCyc = cyc;
                sbQ.push_back(n);
                lastG = e1;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_rsp"}, {11'd0, rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_err, rsp_result}, 32'd0);
        checkOutput({tag, "_alu"}, {alu_op, alu_x[11:0], alu_y}, 32'd0);
        checkOutput({tag, "_aluxhi"}, 32'(alu_x[15:12]), 32'd0);
        checkOutput({tag, "_ready"}, {30'd0, req0_ready, req1_ready}, 32'd0);
    endtask

    initial begin
        int n;
        #1;
        checkResetOutputs("reset_init");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Add with carry-out and zero result on port 0
        applyStimulus(0, 4'b0000, 16'hFFFF, 16'h0001);

        // Both ports continuously requesting: alternation (or port 0 only when fixed priority)
        fork
            begin repeat (4) applyStimulus(0, 4'b0100, 16'h00F0, 16'h0FF0); end
            begin repeat (4) applyStimulus(1, 4'b0110, 16'hAAAA, 16'h5555); end
        join

        // Multiply latency and divide, including divide by zero
        applyStimulus(1, 4'b0010, 16'd300, 16'd200);
        applyStimulus(0, 4'b0011, 16'd100, 16'd0);
        applyStimulus(0, 4'b0011, 16'd100, 16'd7);

        // Consumer stalls while port 1 keeps requesting
        stallCycles = 16;
        rsp_ready = 1'b0;
        applyStimulus(1, 4'b0001, 16'd5, 16'd9);
        applyStimulus(1, 4'b0101, 16'h0F00, 16'h00F0);

        // Randomized traffic from both ports with a random consumer
        randReady = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    applyStimulus(0, 4'($urandom_range(0, 8)), 16'($urandom),
                                  ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom));
                    n = $urandom_range(0, 2);
                    if (n > 0) begin repeat (n) @(posedge clk); #1; end
                end
            end
            begin
                for (int j = 0; j < 30; j++) begin
                    applyStimulus(1, 4'($urandom_range(0, 8)), 16'($urandom),
                                  ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(0, 255)));
                    if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
                end
            end
        join

        // Reset asserted in the middle of a multiply
        randReady = 1'b0;
        applyStimulus(1, 4'b0010, 16'd12, 16'd13);
        rst_n = 1'b0;
        sbQ.delete();
        lastG = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkResetOutputs("reset_exec");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fork
            applyStimulus(0, 4'b0000, 16'd1, 16'd2);
            applyStimulus(1, 4'b0000, 16'd3, 16'd4);
        join

        n = 0;
        while (sbQ.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sbQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d outstanding expected 0", sbQ.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
